// File: rtl/avg_uart_pkg.sv
// Shared definitions for the averaged-sample UART transmitter.
//
// Contents:
//   t_tx_state   transmitter FSM states. PARITY exists only when
//                AVG_UART_TX_PARITY_EN is defined.
//   SAMPLE_W     width of one averaged sample (10)
//   BYTE_W       width of one UART payload byte (8)
//   BYTE_A_MARK  upper five bits of byte A. Its MSB set lets a receiver
//                tell byte A from byte B, whose MSB is always 0.
//   byte_a/b     split a sample into its two line bytes
//
// Configuration macro: AVG_UART_TX_PARITY_EN
package avg_uart_pkg;

  localparam int SAMPLE_W = 10;
  localparam int BYTE_W   = 8;

  localparam logic [4:0] BYTE_A_MARK = 5'b10000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef AVG_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } t_tx_state;

  // Byte A carries sample bits [9:7] under the marker.
  function automatic logic [BYTE_W-1:0] byte_a(input logic [2:0] hi);
    return {BYTE_A_MARK, hi};
  endfunction

  // Byte B carries sample bits [6:0]. Its MSB is always clear.
  function automatic logic [BYTE_W-1:0] byte_b(input logic [6:0] lo);
    return {1'b0, lo};
  endfunction

endpackage

// File: rtl/avg_uart_tx_fifo.sv
// sample_fifo: a small synchronous FIFO that buffers averaged samples
// ahead of the UART serialiser.
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset that empties the FIFO
//   push        write request. It is accepted when the FIFO is not full,
//               or when a pop happens in the same cycle.
//   pop         read request; ignored while the FIFO is empty
//   wr_data     data to write
//   rd_data     head of the FIFO. It is valid while empty is low.
//   full        high when the FIFO holds 1<<DEPTH_LOG2 entries
//   empty       high when the FIFO holds no entries
//   level       current occupancy, 0 .. 1<<DEPTH_LOG2
module sample_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_LEVEL);
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // A pop in the same cycle frees the head slot, so a push to a full
  // FIFO can still land.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap modulo the depth; count decides full and empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The storage has no reset. Entries are only read after they are written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/avg_uart_tx.sv
// avg_uart_tx: buffers 10-bit moving-average samples and sends each one as
// two bytes on an 8N1 UART line.
//   Byte A = {1,0000,d[9:7]}; byte B = {0,d[6:0]}.
//   Byte B follows byte A with no idle gap.
//
// Parameters:
//   CLKS_PER_BIT     clock cycles per UART bit (>= 2)
//   FIFO_DEPTH_LOG2  log2 of the sample FIFO depth
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   ena           block enable. While low, strobes are ignored and no new
//                 sample starts. A sample already in flight still finishes.
//   data_i        averaged sample
//   strobe_i      one-cycle pulse that marks data_i as valid
//   tx_o          UART line, registered, idle high
//   busy_o        high while a sample is being serialised
//   overflow_o    sticky flag. Set when a strobe is dropped because the FIFO
//                 is full. Cleared only by reset.
//   fifo_level_o  FIFO occupancy
//
// Configuration macro: AVG_UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module avg_uart_tx
  import avg_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [SAMPLE_W-1:0]      data_i,
  input  logic                     strobe_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     overflow_o,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level_o
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             SEL_A   = 1'b0;
  localparam logic             SEL_B   = 1'b1;

  t_tx_state           state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [2:0]          bit_idx, bit_idx_next;
  logic                byte_sel, byte_sel_next;
  logic [BYTE_W-1:0]   shift, shift_next;
  logic [6:0]          sample_lo, sample_lo_next;
  logic                line;
  logic                bit_end;
  logic                pop;
  logic                push;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] fifo_data;

  assign push = strobe_i && ena;

  sample_fifo #(
    .WIDTH      (SAMPLE_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (data_i),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_o)
  );

  assign busy_o  = (state != IDLE);
  assign bit_end = (cnt == CNT_MAX);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    byte_sel_next  = byte_sel;
    shift_next     = shift;
    sample_lo_next = sample_lo;
    pop            = 1'b0;
    line           = 1'b1;

    // The baud counter runs only while a frame is active. It is always
    // back at zero when the FSM returns to IDLE.
    if (state != IDLE) begin
      cnt_next = bit_end ? '0 : cnt + CNT_ONE;
    end

    case (state)
      IDLE: begin
        if (!fifo_empty && ena) begin
          pop            = 1'b1;
          sample_lo_next = fifo_data[6:0];
          shift_next     = byte_a(fifo_data[9:7]);
          byte_sel_next  = SEL_A;
          state_next     = START;
        end
      end
      START: begin
        line = 1'b0;
        if (bit_end) begin
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        line = shift[bit_idx];
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef AVG_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef AVG_UART_TX_PARITY_EN
      PARITY: begin
        line = ^shift;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        line = 1'b1;
        if (bit_end) begin
          if (byte_sel == SEL_A) begin
            // Byte B starts straight after byte A's stop bit, with no gap.
            byte_sel_next = SEL_B;
            shift_next    = byte_b(sample_lo);
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers. tx_o is registered from the current state, so the
  // line trails the FSM by one cycle and cannot glitch low after a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      byte_sel   <= SEL_A;
      tx_o       <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      byte_sel <= byte_sel_next;
      tx_o     <= line;
      if (strobe_i && ena && fifo_full && !pop) overflow_o <= 1'b1;
    end
  end

  // Data registers. They are only read after IDLE loads them, so they need
  // no reset.
  always_ff @(posedge clk) begin
    shift     <= shift_next;
    sample_lo <= sample_lo_next;
  end

endmodule

// File: tb/tb_avg_uart_tx.sv
module tb_avg_uart_tx;

  localparam int CPB = 4;
`ifdef AVG_UART_TX_PARITY_EN
  localparam int STOP_SLOT = 10;
  localparam int FRAME     = 88;
`else
  localparam int STOP_SLOT = 9;
  localparam int FRAME     = 80;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [9:0] data_i = '0;
  logic       strobe_i = 1'b0;
  logic       tx_o;
  logic       busy_o;
  logic       overflow_o;
  logic [2:0] fifo_level_o;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_epoch = 0;
  logic [7:0] exp_q[$];

  avg_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .data_i(data_i),
    .strobe_i(strobe_i), .tx_o(tx_o), .busy_o(busy_o),
    .overflow_o(overflow_o), .fifo_level_o(fifo_level_o)
  );

  always #5 clk = ~clk;

  always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

  function automatic logic [7:0] model_a(input logic [9:0] d);
    logic [7:0] b;
    b = {5'b10000, d[9:7]};
    return b;
  endfunction

  function automatic logic [7:0] model_b(input logic [9:0] d);
    logic [7:0] b;
    b = {1'b0, d[6:0]};
    return b;
  endfunction

  // UART receiver with scoreboard. Each bit is sampled one cycle into its slot.
  initial begin : rx_mon
    logic [7:0] rx;
    logic       bitv;
    logic [7:0] exp;
    int         ep;
    bit         ok_stop;
    forever begin
      @(negedge clk);
      if (rst_n && tx_o === 1'b0) begin
        ep = rst_epoch;
        rx = '0;
        ok_stop = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= STOP_SLOT; k++) begin
          repeat (CPB) @(negedge clk);
          bitv = tx_o;
          if (k <= 8) rx[k-1] = bitv;
`ifdef AVG_UART_TX_PARITY_EN
          else if (k == 9 && ep == rst_epoch && rst_n) begin
            n_checks++;
            if (bitv !== ^rx) begin
              n_fail++;
              $display("FAIL parity_bit: got %b required %b (byte %h)", bitv, ^rx, rx);
            end
          end
`endif
          if (k == STOP_SLOT) ok_stop = (bitv === 1'b1);
        end
        if (ep == rst_epoch && rst_n) begin
          n_checks++;
          if (!ok_stop) begin
            n_fail++;
            $display("FAIL stop_bit: got 0 required 1 (byte %h)", rx);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: got %h required none", rx);
          end else begin
            exp = exp_q.pop_front();
            if (rx !== exp) begin
              n_fail++;
              $display("FAIL rx_byte: got %h required %h", rx, exp);
            end
          end
        end
      end
    end
  end

  task automatic drive_strobe(input logic [9:0] d, input bit expect_tx);
    @(negedge clk);
    data_i = d;
    strobe_i = 1'b1;
    if (expect_tx) begin
      exp_q.push_back(model_a(d));
      exp_q.push_back(model_b(d));
    end
    @(posedge clk);
    #1;
    strobe_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: pending=%0d busy=%b required pending=0 busy=0",
               name, exp_q.size(), busy_o);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || overflow_o !== 1'b0 || fifo_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got tx=%b busy=%b ovf=%b lvl=%0d required 1 0 0 0",
               tx_o, busy_o, overflow_o, fifo_level_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single;
    drive_strobe(10'h2A5, 1'b1);   // edge N
    n_checks++;
    if (fifo_level_o !== 3'd1) begin
      n_fail++; $display("FAIL single_level_n: got %0d required 1", fifo_level_o);
    end
    @(posedge clk); #1;            // N+1
    n_checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b1 || fifo_level_o !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop: got tx=%b busy=%b lvl=%0d required 1 1 0", tx_o, busy_o, fifo_level_o);
    end
    @(posedge clk); #1;            // N+2
    n_checks++;
    if (tx_o !== 1'b0) begin
      n_fail++; $display("FAIL single_start_fall: got %b required 0", tx_o);
    end
    repeat (3) @(posedge clk); #1; // N+5
    n_checks++;
    if (tx_o !== 1'b0) begin
      n_fail++; $display("FAIL single_start_len: got %b required 0", tx_o);
    end
    @(posedge clk); #1;            // N+6
    n_checks++;
    if (tx_o !== 1'b1) begin
      n_fail++; $display("FAIL single_bit0: got %b required 1", tx_o);
    end
    repeat (FRAME - 6) @(posedge clk); #1;
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_end: got %b required 1", busy_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_drop: got busy=%b tx=%b required 0 1", busy_o, tx_o);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL single_bytes: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_ena;
    bit bad;
    int cyc;
    ena = 1'b0;
    drive_strobe(10'h155, 1'b0);
    n_checks++;
    if (fifo_level_o !== 3'd0) begin
      n_fail++; $display("FAIL ena_no_push: got %0d required 0", fifo_level_o);
    end
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL ena_line_idle: got activity required idle");
    end
    ena = 1'b1;
    drive_strobe(10'h3C3, 1'b1);
    drive_strobe(10'h0F0, 1'b1);
    n_checks++;
    if (fifo_level_o !== 3'd1) begin
      n_fail++; $display("FAIL ena_queued: got %0d required 1", fifo_level_o);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    cyc = 0;
    while (busy_o !== 1'b0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 2 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_finish_sample: got pending=%0d busy=%b required 2 0", exp_q.size(), busy_o);
    end
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_level_o !== 3'd1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL ena_hold_queue: got activity required held");
    end
    @(negedge clk);
    ena = 1'b1;
    wait_drain("ena");
  endtask

  task automatic test_overflow;
    for (int k = 1; k <= 6; k++) begin
      drive_strobe(10'(k), k <= 5);
      if (k == 5) begin
        n_checks++;
        if (overflow_o !== 1'b0) begin
          n_fail++; $display("FAIL ovf_early: got %b required 0", overflow_o);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (overflow_o !== 1'b1 || fifo_level_o !== 3'd4) begin
          n_fail++;
          $display("FAIL ovf_set: got ovf=%b lvl=%0d required 1 4", overflow_o, fifo_level_o);
        end
      end
    end
    wait_drain("ovf");
    n_checks++;
    if (overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b required 1", overflow_o);
    end
  endtask

  task automatic test_reset_midframe;
    bit bad;
    drive_strobe(10'h2A5, 1'b0);
    drive_strobe(10'h111, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (busy_o !== 1'b1 || fifo_level_o !== 3'd1) begin
      n_fail++; $display("FAIL rst_pre: got busy=%b lvl=%0d required 1 1", busy_o, fifo_level_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_o !== 1'b1 || fifo_level_o !== 3'd0 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got tx=%b lvl=%0d busy=%b ovf=%b required 1 0 0 0",
               tx_o, fifo_level_o, busy_o, overflow_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL rst_glitch: got 0 on line required 1");
    end
    drive_strobe(10'h001, 1'b1);
    wait_drain("rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_ena();
    test_overflow();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/avg_uart_tx.md
# avg_uart_tx

Downstream consumer of the 10-bit moving-average stage. Accepts each averaged sample on a single-cycle strobe and buffers it in a small FIFO. Transmits every sample as two self-synchronising bytes on an 8N1 UART line, so the filtered stream can be logged off-chip through one output pin.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 2
- FIFO_DEPTH_LOG2, 2, FIFO depth = 1 << FIFO_DEPTH_LOG2 samples

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous and active-low
- ena  input  1  block enable; when low, strobes are ignored and no new sample is started
- data_i  input  10  averaged sample from the moving-average stage
- strobe_i  input  1  one-cycle pulse; data_i valid in the same cycle
- tx_o  output  1  UART line, idle high
- busy_o  output  1  high while a sample is being serialised
- overflow_o  output  1  sticky; set when a strobe arrives with the FIFO full
- fifo_level_o  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy

## Operation
- Reset values: tx_o=1, busy_o=0, overflow_o=0, fifo_level_o=0. The FIFO is cleared and the FSM is set to IDLE.
- Push: strobe_i && ena && !full writes data_i on that edge.
- Strobe with FIFO full: the sample is dropped, FIFO contents are unchanged, and overflow_o is set. overflow_o clears only on reset.
- Pop and push in the same cycle are both honoured, including when the FIFO is full (the pop frees the slot first).
- Byte encoding of sample d:
  - byte A = {1'b1, 4'b0000, d[9:7]}
  - byte B = {1'b0, d[6:0]}
  - The MSB marks byte A so a receiver can resynchronise.
- Line format: start bit 0, 8 data bits LSB first, 1 stop bit 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty and ena, pop the FIFO, latch the sample, set byte_sel=A, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: drive shift[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. If byte_sel=A, set byte_sel=B and go to START. If byte_sel=B, go to IDLE.
- busy_o = (state != IDLE).
- ena deasserted mid-sample: the current sample (both bytes) completes; the next pop is blocked until ena returns.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, wraps at each bit boundary.
- FIFO: read/write pointers of FIFO_DEPTH_LOG2 bits that wrap modulo depth. full/empty are derived from a count of FIFO_DEPTH_LOG2+1 bits.

## Timing
- Strobe sampled at edge N with FIFO empty and FSM in IDLE:
  - FIFO written at edge N.
  - FSM pops at edge N+1.
  - tx_o falls at edge N+2.
- Per sample:
  - 2 × 10 × CLKS_PER_BIT cycles of line activity, with no gap between byte A and byte B.
  - At least one IDLE cycle between consecutive samples.
- Throughput limit: one sample per (20 × CLKS_PER_BIT + 1) cycles. Faster strobes fill the FIFO.
- Asynchronous reset mid-frame: tx_o returns to 1 immediately, with no glitch to 0 after release.

## Configuration
- Macro AVG_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, and the per-sample line time becomes 22 × CLKS_PER_BIT.
- Undefined: PARITY state and logic are absent; the line is pure 8N1.

## Structure
- Package avg_uart_pkg holds:
  - state enum t_tx_state (IDLE, START, DATA, PARITY, STOP; PARITY present only under the macro)
  - constants SAMPLE_W=10, BYTE_W=8
  - the byte-A marker pattern
- Sub-module sample_fifo: parameterised width/depth synchronous FIFO with push, pop, full, empty and level.
- Top-level avg_uart_tx holds the FSM, baud counter, shift register and overflow flag.

## Test plan
- Reset check: CLKS_PER_BIT=4, hold rst_n low → tx_o=1, busy_o=0, overflow_o=0, fifo_level_o=0.
- Single sample: strobe data_i=0x2A5 → line carries byte 0x85 then byte 0x25. tx_o falls 2 cycles after the strobe, each bit lasts 4 cycles, and busy_o drops after 80 cycles.
- Overflow: 6 back-to-back strobes with values 1..6, FIFO depth 4 → samples 1–5 transmitted in order, 6 dropped, overflow_o=1 from the 6th strobe edge.
- ena low: strobe with ena=0 → no push, tx_o stays 1. Deassert ena during byte A of a sample → byte B still completes, and a queued sample waits until ena=1.
- Reset mid-frame: assert rst_n=0 during the DATA state → tx_o=1 and fifo_level_o=0 immediately. After release, a fresh strobe of 0x001 sends bytes 0x80 and 0x01.
- Parity build (AVG_UART_TX_PARITY_EN): sample 0x2A5 → bytes 0x85 and 0x25 each carry parity bit 1, and the frame totals 88 cycles.
